// File: rtl/nsc8_pkg.sv
// NSC-8 shared types and constants.
// Used by the program loader and its UART receiver.
package nsc8_pkg;

  typedef enum logic {
    LOAD,
    RUN
  } ld_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int RAM_DEPTH  = 16;
  localparam int WORD_WIDTH = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver with 2-FF input synchronizer.
// Emits one-cycle byte_valid / byte_err pulses at the stop-bit sample.
module uart_rx_byte
  import nsc8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic                  byte_valid,
  output logic                  byte_err,
  output logic [DATA_WIDTH-1:0] byte_out
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_t state, state_nx;

  logic                  rx_meta;
  logic                  rx_s;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  err_hold;
  logic                  half_tick;
  logic                  full_tick;
  logic                  sample;

  assign half_tick = (timer == HALF_M1);
  assign full_tick = (timer == FULL_M1);
  assign sample    = (state == START && half_tick)
                  || (state == DATA && full_tick)
                  || (state == STOP && full_tick);
  assign byte_out  = shift;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // After a bad stop bit, wait for the line to go idle so a break
  // condition is not mistaken for a new start bit.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!rx_s) state_nx = START;
      START: if (half_tick) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (full_tick && bit_cnt == LAST_BIT) state_nx = STOP;
      STOP: begin
        if (err_hold) begin
          if (rx_s) state_nx = IDLE;
        end else if (full_tick && rx_s) begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    unique case (state)
      STOP: begin
        byte_valid = !err_hold && full_tick && rx_s;
        byte_err   = !err_hold && full_tick && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      err_hold <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (state == IDLE || sample) timer <= '0;
      else                         timer <= timer + 1'b1;
      if (state == START) bit_cnt <= '0;
      if (state == DATA && full_tick) begin
        shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == IDLE) err_hold <= 1'b0;
      else if (state == STOP && full_tick && !rx_s) err_hold <= 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// NSC-8 serial program loader: writes UART bytes into program RAM
// from address 0, holding the CPU ring counter in reset until full.
module program_loader
  import nsc8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = $clog2(RAM_DEPTH),
  parameter int DATA_WIDTH   = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  load_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  cpu_reset_ring,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ld_state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] cnt;
  logic                  byte_valid;
  logic                  byte_err;
  logic [DATA_WIDTH-1:0] byte_out;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .byte_out  (byte_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: if (ram_we && ram_addr == LAST_ADDR) state_nx = RUN;
      RUN:  if (load_req) state_nx = LOAD;
    endcase
  end

  always_comb begin
    cpu_reset_ring = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state)
      LOAD: begin
        cpu_reset_ring = 1'b1;
        busy           = 1'b1;
      end
      RUN: done = 1'b1;
    endcase
  end

  // A framing error leaves cnt alone so the sender simply retries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      cnt         <= '0;
      frame_error <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (state == LOAD) begin
        if (byte_valid) begin
          ram_we   <= 1'b1;
          ram_addr <= cnt;
          ram_data <= byte_out;
          cnt      <= cnt + 1'b1;
        end
        if (byte_err) frame_error <= 1'b1;
      end else if (load_req) begin
        cnt         <= '0;
        frame_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Drives UART frames on rx and checks the RAM write stream.
module tb_program_loader;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       load_req = 1'b0;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       cpu_reset_ring;
  logic       busy;
  logic       done;
  logic       frame_error;

  int total = 0;
  int bad = 0;

  logic [11:0] wq[$];
  logic        prev_we = 1'b0;
  logic [3:0]  prev_addr = '0;

  program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (4),
    .DATA_WIDTH  (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx            (rx),
    .load_req      (load_req),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .ram_we        (ram_we),
    .cpu_reset_ring(cpu_reset_ring),
    .busy          (busy),
    .done          (done),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we) begin
      chk("we_single", {31'd0, prev_we}, 0);
      wq.push_back({ram_addr, ram_data});
    end
    if (prev_we && prev_addr == 4'hF) begin
      chk("ring_off", {31'd0, cpu_reset_ring}, 0);
      chk("done_on", {31'd0, done}, 1);
    end
    prev_we   = ram_we;
    prev_addr = ram_addr;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(CPB);
    end
    rx = stop;
    hold(CPB);
    if (!stop) begin
      rx = 1'b0;
      hold(2 * CPB);
    end
    rx = 1'b1;
    hold(2 * CPB);
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
    logic [11:0] e;
    int n = 0;
    while (wq.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (wq.size() == 0) begin
      chk("wr_seen", wq.size(), 1);
    end else begin
      e = wq.pop_front();
      chk("wr_addr", {28'd0, e[11:8]}, {28'd0, a});
      chk("wr_data", {24'd0, e[7:0]}, {24'd0, d});
    end
  endtask

  task automatic pulse_req;
    @(posedge clk);
    #1 load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ring"}, {31'd0, cpu_reset_ring}, 1);
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_we"}, {31'd0, ram_we}, 0);
    chk({tag, "_addr"}, {28'd0, ram_addr}, 0);
    chk({tag, "_data"}, {24'd0, ram_data}, 0);
    chk({tag, "_ferr"}, {31'd0, frame_error}, 0);
  endtask

  initial begin
    int n;
    hold(3);
    @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    hold(4);

    // short low glitch must not start a frame
    rx = 1'b0;
    hold(3);
    rx = 1'b1;
    hold(200);
    chk("glitch_nowr", wq.size(), 0);

    for (int i = 0; i < 5; i++) begin
      send_byte(8'(i), 1'b1);
      expect_write(4'(i), 8'(i));
    end
    send_byte(8'h3C, 1'b0);
    chk("ferr_set", {31'd0, frame_error}, 1);
    chk("bad_nowr", wq.size(), 0);
    send_byte(8'h3C, 1'b1);
    expect_write(4'd5, 8'h3C);
    chk("ferr_sticky", {31'd0, frame_error}, 1);
    for (int i = 6; i < 16; i++) begin
      send_byte(8'(i), 1'b1);
      expect_write(4'(i), 8'(i));
    end
    hold(4);
    @(negedge clk);
    chk("run_done", {31'd0, done}, 1);
    chk("run_busy", {31'd0, busy}, 0);

    // bytes received while running are discarded
    send_byte(8'hAA, 1'b1);
    hold(10);
    chk("run_nowr", wq.size(), 0);
    chk("run_ferr", {31'd0, frame_error}, 1);
    pulse_req();
    chk("req_ring", {31'd0, cpu_reset_ring}, 1);
    chk("req_ferr", {31'd0, frame_error}, 0);
    send_byte(8'h55, 1'b1);
    expect_write(4'd0, 8'h55);
    for (int i = 1; i < 7; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
      expect_write(4'(i), 8'h10 + 8'(i));
    end

    // reset pulse in the middle of the byte for address 7
    fork
      send_byte(8'hFF, 1'b1);
      begin
        hold(60);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("mid");
        reset_n = 1'b1;
      end
    join
    hold(10);
    chk("mid_nowr", wq.size(), 0);
    send_byte(8'h77, 1'b1);
    expect_write(4'd0, 8'h77);

    // load_req while loading has no effect
    pulse_req();
    chk("ldreq_busy", {31'd0, busy}, 1);
    for (int i = 1; i < 16; i++) begin
      send_byte(8'(i) ^ 8'hC0, 1'b1);
      expect_write(4'(i), 8'(i) ^ 8'hC0);
    end
    hold(4);
    chk("run2_done", {31'd0, done}, 1);

    // load_req in the same cycle as byte_valid while running
    fork
      send_byte(8'h42, 1'b1);
      begin
        n = 0;
        @(negedge clk);
        while (!dut.u_rx.byte_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("bv_seen", {31'd0, dut.u_rx.byte_valid}, 1);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("tie_ring", {31'd0, cpu_reset_ring}, 1);
      end
    join
    hold(4);
    chk("tie_nowr", wq.size(), 0);
    chk("tie_busy", {31'd0, busy}, 1);
    send_byte(8'h99, 1'b1);
    expect_write(4'd0, 8'h99);
    hold(10);
    chk("end_nowr", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
